uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_byte_fifo.sv | 74 +++++++
 rtl/uart_tx_sequencer.sv | 151 +++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit sequencer:
//   seq_state_t  - sequencer FSM states
//   hold_cycles  - clk cycles per baud period (integer division, minimum 1),
//                  used to stretch strobes so the baud-domain UART sees them.
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      START     = 2'd2,
      WAIT_DONE = 2'd3
   } seq_state_t;

   function automatic int hold_cycles(input int baud_rate, input int clock_freq);
      int h;
      h = clock_freq / baud_rate;
      return (h < 1) ? 1 : h;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// ----------------------------------------------------------------------------
// uart_byte_fifo
// Byte FIFO feeding the UART sequencer. Pointers wrap modulo DEPTH (a power
// of 2), occupancy is tracked in a separate counter one bit wider than the
// pointers so full and empty are unambiguous.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   wr_en, wr_data  - enqueue request; dropped (and overflow set) when full
//   rd_en           - dequeue request; ignored when empty
//   rd_data         - head byte (combinational read of the head slot)
//   full, empty     - occupancy flags derived from the registered count
//   count           - occupancy, 0..DEPTH
//   overflow        - sticky, set by any write attempted while full
// ----------------------------------------------------------------------------
module uart_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // full is taken from the registered count, so a pop in the same cycle
   // never frees room for a write that arrived while full.
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push    = wr_en & ~full;
   assign pop     = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage is not reset; a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_en && full)
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_sequencer.sv
// ----------------------------------------------------------------------------
// uart_tx_sequencer
// Queues bytes and hands them one at a time to a UART transmitter running in
// a slower baud-clock domain. Each byte is presented on uart_data, then
// load_data and start_transmit are each held for HOLD_CYCLES clk cycles so
// the baud domain is guaranteed to sample them. The sequencer then waits for
// a rising edge of tx_done (synchronized into clk) before the next byte.
// Ports:
//   clk, reset              - system clock, synchronous active-high reset
//   wr_data, wr_en          - byte enqueue
//   full, empty, count      - FIFO status
//   overflow                - sticky dropped-write flag
//   uart_data               - byte to the UART, stable from pop to IDLE
//   load_data               - UART load strobe (HOLD_CYCLES long)
//   start_transmit          - UART start strobe (HOLD_CYCLES long)
//   tx_done                 - UART finish, asynchronous to clk
//   busy                    - sequencer not in IDLE
// ----------------------------------------------------------------------------
module uart_tx_sequencer
   import uart_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int BAUD_RATE  = 9600,
   parameter int CLOCK_FREQ = 38400000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [7:0]               uart_data,
   output logic                     load_data,
   output logic                     start_transmit,
   input  logic                     tx_done,
   output logic                     busy
);

   localparam int HOLD_CYCLES = hold_cycles(BAUD_RATE, CLOCK_FREQ);
   localparam int HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   seq_state_t    state;
   logic [HW-1:0] hold_cnt;
   logic          hold_last;
   logic          done_latch;
   logic          sync1;
   logic          sync2;
   logic          sync2_d;
   logic          done_pulse;
   logic          pop;
   logic [7:0]    head;

   // Pop in the IDLE cycle itself, so a queued byte goes out back-to-back
   // right after the previous transfer completes.
   assign pop        = (state == IDLE) && !empty;
   assign hold_last  = (hold_cnt == HOLD_LAST);
   assign done_pulse = sync2 & ~sync2_d;

   uart_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   // tx_done crosses from the baud domain: two flops, then edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_d <= 1'b0;
      end else begin
         sync1   <= tx_done;
         sync2   <= sync1;
         sync2_d <= sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         uart_data      <= 8'h00;
         load_data      <= 1'b0;
         start_transmit <= 1'b0;
         busy           <= 1'b0;
         hold_cnt       <= '0;
         done_latch     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  uart_data <= head;
                  load_data <= 1'b1;
                  busy      <= 1'b1;
                  hold_cnt  <= '0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               // done_pulse here belongs to an earlier byte; ignore it.
               if (hold_last) begin
                  load_data      <= 1'b0;
                  start_transmit <= 1'b1;
                  hold_cnt       <= '0;
                  state          <= START;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            START: begin
               // A fast UART may finish before the start strobe ends;
               // remember it so WAIT_DONE does not miss the edge.
               if (done_pulse)
                  done_latch <= 1'b1;
               if (hold_last) begin
                  start_transmit <= 1'b0;
                  hold_cnt       <= '0;
                  state          <= WAIT_DONE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (done_pulse || done_latch) begin
                  done_latch <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               load_data      <= 1'b0;
               start_transmit <= 1'b0;
               busy           <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_sequencer
// Directed bench for uart_tx_sequencer with CLOCK_FREQ=16, BAUD_RATE=4
// (4-cycle strobes) and DEPTH=4. Inputs change and outputs are sampled 1ns
// after each rising edge.
// ----------------------------------------------------------------------------
module tb_uart_tx_sequencer;

   logic       clk;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       overflow;
   logic [7:0] uart_data;
   logic       load_data;
   logic       start_transmit;
   logic       tx_done;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   uart_tx_sequencer #(
      .DEPTH      (4),
      .BAUD_RATE  (4),
      .CLOCK_FREQ (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .full           (full),
      .empty          (empty),
      .count          (count),
      .overflow       (overflow),
      .uart_data      (uart_data),
      .load_data      (load_data),
      .start_transmit (start_transmit),
      .tx_done        (tx_done),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Single-cycle write; returns one cycle after the write cycle.
   task automatic write(input logic [7:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_load(input string tag);
      int n = 0;
      while (!load_data && n < 50) begin
         step();
         n++;
      end
      chk({tag, "_load_seen"}, load_data, 1);
   endtask

   // Rising tx_done; 2 sync flops + 1 FSM edge -> IDLE after 3 edges.
   task automatic send_done();
      tx_done = 1'b1;
      repeat (3) step();
      tx_done = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      tx_done = 1'b0;
      do_reset();

      // ---- reset values
      chk("rst_full",  full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_ovf",   overflow, 0);
      chk("rst_udata", uart_data, 0);
      chk("rst_load",  load_data, 0);
      chk("rst_start", start_transmit, 0);
      chk("rst_busy",  busy, 0);

      // ---- single byte: latency and strobe widths
      write(8'hA5);                        // now cycle N+1
      chk("t1_cnt1",   count, 1);
      chk("t1_load_n1", load_data, 0);
      step();                              // N+2
      chk("t1_busy",   busy, 1);
      chk("t1_cnt0",   count, 0);
      for (int i = 0; i < 4; i++) begin
         chk("t1_load",  load_data, 1);
         chk("t1_nost",  start_transmit, 0);
         chk("t1_udata", uart_data, 8'hA5);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         chk("t1_start", start_transmit, 1);
         chk("t1_noload", load_data, 0);
         step();
      end
      chk("t1_wait_st", start_transmit, 0);
      chk("t1_wait_busy", busy, 1);
      send_done();
      chk("t1_idle", busy, 0);

      // ---- fill to full while busy, overflow, order preserved
      do_reset();
      write(8'h00);
      wait_load("t2_prime");
      repeat (8) step();                   // WAIT_DONE
      wr_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wr_data = 8'(k);
         step();
      end
      chk("t2_full",  full, 1);
      chk("t2_cnt4",  count, 4);
      chk("t2_ovf0",  overflow, 0);
      wr_data = 8'h05;
      step();
      wr_en = 1'b0;
      chk("t2_ovf1",  overflow, 1);
      chk("t2_cnt4b", count, 4);
      for (int k = 1; k <= 4; k++) begin
         send_done();                      // IDLE, pop this cycle
         chk("t2_b2b_idle", busy, 0);
         step();
         chk("t2_load", load_data, 1);
         chk("t2_order", uart_data, 32'(k));
         repeat (8) step();
         chk("t2_hold", uart_data, 32'(k));
      end
      send_done();
      chk("t2_done_busy",  busy, 0);
      chk("t2_done_empty", empty, 1);

      // ---- reset in LOAD with 3 bytes queued (overflow still set)
      wr_en = 1'b1;
      wr_data = 8'h11; step();
      wr_data = 8'h22; step();
      wr_data = 8'h33; step();
      wr_data = 8'h44; step();
      wr_en = 1'b0;
      chk("t3_inload", load_data, 1);
      chk("t3_cnt3",   count, 3);
      chk("t3_ovf1",   overflow, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t3_busy",  busy, 0);
      chk("t3_empty", empty, 1);
      chk("t3_cnt",   count, 0);
      chk("t3_load",  load_data, 0);
      chk("t3_ovf",   overflow, 0);
      chk("t3_udata", uart_data, 0);
      repeat (3) step();
      chk("t3_stay_idle", busy, 0);

      // ---- tx_done already high: needs a fresh rising edge
      tx_done = 1'b1;
      do_reset();
      repeat (3) step();
      write(8'h3C);
      wait_load("t4");
      repeat (8) step();
      repeat (6) step();
      chk("t4_stuck_hi", busy, 1);
      tx_done = 1'b0;
      repeat (3) step();
      chk("t4_stuck_lo", busy, 1);
      tx_done = 1'b1;
      repeat (2) step();
      chk("t4_pre_exit", busy, 1);
      step();
      chk("t4_exit", busy, 0);
      tx_done = 1'b0;

      // ---- tx_done rises during START: WAIT_DONE lasts one cycle
      do_reset();
      write(8'h5A);
      wait_load("t5");                     // L
      repeat (4) step();                   // L+4, first START cycle
      chk("t5_start", start_transmit, 1);
      tx_done = 1'b1;
      repeat (4) step();                   // L+8, WAIT_DONE
      chk("t5_wait_busy", busy, 1);
      chk("t5_wait_st",   start_transmit, 0);
      step();                              // L+9
      chk("t5_exit", busy, 0);
      tx_done = 1'b0;

      // ---- full + IDLE pop + write in same cycle: write dropped
      do_reset();
      write(8'h77);
      wait_load("t6_prime");
      repeat (8) step();
      wr_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wr_data = 8'(k);
         step();
      end
      wr_en = 1'b0;
      send_done();                         // IDLE with full=1
      chk("t6_full_idle", full, 1);
      write(8'hEE);
      chk("t6_ovf",  overflow, 1);
      chk("t6_cnt3", count, 3);
      chk("t6_load", load_data, 1);
      chk("t6_head", uart_data, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Watchdog so the run cannot hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
